mc_control: RTL
===============

// Module: mc_control
// PURPOSE
// - Multicycle main controller: sequences the shared IFU/regfile/ALU/memory datapath
//   one instruction at a time (fetch, decode, execute, memory, writeback).
// - Replaces the combinational single-cycle control; the datapath muxes and enables are driven from here.
// - Stalls on memory wait states and counts retired instructions.
// PARAMETERS
// - CNT_W   32  width of retired-instruction counter
// PORTS
// - clk          in   1   rising-edge clock
// - rst_n        in   1   async active-low reset
// - opcode       in   6   instr[31:26] from IR
// - funct        in   6   instr[5:0] from IR
// - zero         in   1   ALU zero flag
// - mem_ready    in   1   memory access completes this cycle
// - mem_read     out  1   memory read strobe
// - mem_write    out  1   memory write strobe
// - iord         out  1   0 = address from PC, 1 = address from ALUOut
// - ir_write     out  1   load IR
// - pc_en        out  1   load PC (pc_write | (branch & zero))
// - pc_src       out  2   0 = ALU result, 1 = ALUOut, 2 = jump target
// - alu_src_a    out  2   0 = PC, 1 = reg A, 2 = zero-extended shamt
// - alu_src_b    out  2   0 = reg B, 1 = const 4, 2 = signext imm, 3 = signext imm<<2
// - alu_ctrl     out  3   000 and, 001 or, 010 add, 110 sub, 111 slt, 011 sll
// - reg_dst      out  1   0 = rt, 1 = rd
// - mem_to_reg   out  1   0 = ALUOut, 1 = MDR
// - reg_write    out  1   regfile write enable
// - instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// - illegal      out  1   sticky, set on unknown opcode/funct (ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=FETCH, instr_count=0, illegal=0; all strobes/enables 0; muxes 0.
// - Moore outputs decoded from state, except pc_en and ir_write in FETCH, which are gated by mem_ready.
// - FETCH: iord=0, mem_read=1, src_a=0, src_b=1, add; hold while !mem_ready; on mem_ready:
//   ir_write=1, pc_write=1, pc_src=0, go to DECODE.
// - DECODE: src_a=0, src_b=3, add (branch target into ALUOut). Dispatch on opcode:
//   000000 -> RTYPE_EX; 100011/101011 -> MEMADR; 000100 -> BEQ_EX; 001000 -> ADDI_EX; 000010 -> J_EX.
// - MEMADR: src_a=1, src_b=2, add -> MEMRD (lw) or MEMWR (sw).
// - MEMRD: iord=1, mem_read=1, hold until mem_ready -> MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
// - MEMWR: iord=1, mem_write=1, hold until mem_ready; retire -> FETCH.
// - RTYPE_EX: src_a=1 (2 when funct=000000 sll), src_b=0, alu_ctrl from funct:
//   100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll. -> RTYPE_WB.
// - RTYPE_WB: reg_dst=1, mem_to_reg=0, reg_write=1. ADDI_EX: src_a=1, src_b=2, add. ADDI_WB: reg_dst=0, reg_write=1.
// - BEQ_EX: src_a=1, src_b=0, sub, branch=1, pc_src=1. J_EX: pc_write=1, pc_src=2.
// - Retire (instr_count += 1) on the final cycle of each instruction: MEMWB, MEMWR&mem_ready, RTYPE_WB,
//   ADDI_WB, BEQ_EX, J_EX; then next state = FETCH. Counter wraps 0xFFFFFFFF -> 0 silently.
// - Latency in cycles (zero wait states): lw 5, sw 4, R/addi 4, beq 3, j 3. Each mem wait cycle adds 1.
// - mem_read/mem_write remain asserted with constant address for the whole stall; never both high.
// - rst_n asserted mid-instruction: abort immediately, no partial reg_write/mem_write after reset edge.
// - Unknown funct under R-type: alu_ctrl=010, writeback still occurs (unless trapped, below).
// CONFIGURATION
// - MC_CONTROL_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE or unknown funct in RTYPE_EX -> HALT;
//   illegal=1 (sticky); HALT holds all enables 0 forever until reset; not retired.
// - Not defined: unknown opcode -> FETCH as NOP (retired, count+1); illegal tied 0; no HALT state.
// TESTING
// - Reset: rst_n=0 mid-MEMRD -> state FETCH, all strobes 0, instr_count=0 within same cycle.
// - add $3,$1,$2 (funct 100000), mem_ready=1 -> 4 cycles, RTYPE_WB reg_write=1 reg_dst=1 alu_ctrl=010, count=1.
// - lw with mem_ready low 2 cycles in MEMRD -> mem_read/iord held 3 cycles, total 7, mem_to_reg=1 in MEMWB.
// - beq zero=1 -> pc_en=1 pc_src=1 in BEQ_EX; zero=0 -> pc_en=0; both 3 cycles, count+1.
// - sll (funct 000000) -> alu_src_a=2, alu_ctrl=011; j -> pc_src=2 pc_en=1; count preloaded 0xFFFFFFFF wraps to 0.
// - Opcode 111111: with _EN -> HALT, illegal=1, pc_en stays 0; without -> FETCH after DECODE, count+1.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multicycle main controller for the shared IFU/regfile/ALU/memory
// datapath. Sequences fetch/decode/execute/memory/writeback, stalls on memory
// wait states and counts retired instructions.
// Build option: define MC_CONTROL_ILLEGAL_TRAP_EN to trap unknown opcode/funct
// into a sticky HALT state with the illegal flag set.
module mc_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SLL = 3'b011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPE_EX,
        S_RTYPE_WB,
        S_ADDI_EX,
        S_ADDI_WB,
        S_BEQ_EX,
        S_J_EX
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             retire;
    logic             pc_write;
    logic             branch;
    logic [2:0]       funct_alu;
    logic [CNT_W-1:0] count_q;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    logic             funct_known;
    logic             trap;
    logic             illegal_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // R-type funct to ALU operation; unknown funct falls back to add
    always_comb begin
        funct_alu = ALU_ADD;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        funct_known = 1'b1;
`endif
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            FN_SLL:  funct_alu = ALU_SLL;
            default: begin
                funct_alu = ALU_ADD;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                funct_known = 1'b0;
`endif
            end
        endcase
    end

    // Next-state and retire decode
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        trap    = 1'b0;
`endif
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:    state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:      state_d = S_BEQ_EX;
                    OP_ADDI:     state_d = S_ADDI_EX;
                    OP_J:        state_d = S_J_EX;
                    default: begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
                        trap    = 1'b1;
`else
                        // unknown opcode retires as a NOP straight from decode
                        state_d = S_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_RTYPE_EX: begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                if (!funct_known) begin
                    state_d = S_HALT;
                    trap    = 1'b1;
                end else begin
                    state_d = S_RTYPE_WB;
                end
`else
                state_d = S_RTYPE_WB;
`endif
            end
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BEQ_EX, S_J_EX: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Moore control decode; held at zero while reset is asserted
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = '0;
        alu_src_a  = '0;
        alu_src_b  = '0;
        alu_ctrl   = '0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMADR, S_ADDI_EX: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_RTYPE_EX: begin
                    alu_src_a = (funct == FN_SLL) ? 2'd2 : 2'd1;
                    alu_ctrl  = funct_alu;
                end
                S_RTYPE_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_ADDI_WB: reg_write = 1'b1;
                S_BEQ_EX: begin
                    alu_src_a = 2'd1;
                    alu_ctrl  = ALU_SUB;
                    branch    = 1'b1;
                    pc_src    = 2'd1;
                end
                S_J_EX: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign pc_en = pc_write | (branch & zero);

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      count_q <= '0;
        else if (retire) count_q <= count_q + CNT_W'(1);
    end

    assign instr_count = count_q;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    // Sticky illegal flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    illegal_q <= 1'b0;
        else if (trap) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule
